afifo_wr_arbiter: RTL and testbench
===================================

// Module: afifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the async-FIFO write port among NUM_REQ requesters in the wclk domain.
//  Grants one requester a locked burst of up to MAX_BURST words, then drives winc/wdata honouring wfull.
//  Sits between the producer sources and the afifo write interface (the port the write monitor samples).
// PARAMETERS
//  DATA_WIDTH  32  width of wdata and of each requester data lane
//  NUM_REQ     4   number of requesters, 2..16
//  MAX_BURST   8   max words per grant before forced re-arbitration, >=1
//  CNT_WIDTH   16  width of per-requester statistics counters (only with AFIFO_WR_ARB_STATS_EN)
// PORTS
//  wclk        in   1                    write-domain clock
//  wrst_n      in   1                    asynchronous active-low reset
//  req_valid   in   NUM_REQ              requester i holds a word
//  req_data    in   NUM_REQ*DATA_WIDTH   lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready   out  NUM_REQ              word on lane i accepted this cycle when valid&ready
//  winc        out  1                    FIFO write enable
//  wdata       out  DATA_WIDTH           FIFO write data
//  wfull       in   1                    FIFO full flag (wclk domain)
//  busy        out  1                    1 while in BURST state
//  owner_id    out  $clog2(NUM_REQ)      index of current burst owner
//  wr_count    out  NUM_REQ*CNT_WIDTH    per-requester accepted-word count (AFIFO_WR_ARB_STATS_EN only)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, owner_id=0, last=NUM_REQ-1, burst_cnt=0,
//   busy=0, req_ready=0, winc=0, wdata=0, wr_count=0. Reset mid-burst discards burst; no partial write.
//  FSM IDLE: if |req_valid, pick first i with req_valid[i] searching from last+1 modulo NUM_REQ;
//   register owner_id=i, last=i, burst_cnt=0, go BURST next edge. Else stay. No outputs asserted.
//  FSM BURST (combinational from registered owner):
//   req_ready[owner]=~wfull; other req_ready bits 0; winc=req_valid[owner]&~wfull; wdata=lane[owner].
//   wdata is 0 when winc=0.
//   Transfer = winc. On transfer burst_cnt++.
//   Exit to IDLE when transfer with burst_cnt==MAX_BURST-1, or req_valid[owner]==0 with wfull==0.
//  wfull=1 in BURST: stall; winc=0, ready=0, burst_cnt and owner held; drop of req_valid while full
//   does not release the burst (exit re-checked once wfull clears).
//  Latency: first word to FIFO 1 cycle after req_valid seen in IDLE; 1 idle arbitration cycle between bursts.
//  Fairness: a requester continuously valid waits at most (NUM_REQ-1)*(MAX_BURST+1) write cycles, excluding full stalls.
//  Requester rule: once req_valid asserted it must hold data stable until valid&ready (checked by assertion).
//  burst_cnt width $clog2(MAX_BURST)+1; never exceeds MAX_BURST-1.
// CONFIGURATION
//  AFIFO_WR_ARB_STATS_EN defined: wr_count lane i increments on each transfer from requester i,
//   saturates at all-ones, reset to 0.
//  Undefined: wr_count port and counters absent; no other behaviour change.
// STRUCTURE
//  afifo_pkg: arb_state_e {ARB_IDLE, ARB_BURST}; localparam helper for owner index width.
//  Sub-module afifo_rr_pick: combinational round-robin priority pick (req vector, last -> index, found).
//  FSM, burst counter, output mux and optional stats stay in afifo_wr_arbiter.
// TESTING
//  Reset mid-burst after 3 words -> winc=0, busy=0 same cycle as wrst_n low; req0 granted first after release.
//  NUM_REQ=4, MAX_BURST=8, all valid always, wfull=0 -> grants 0,1,2,3,0 each 8 words, 1 idle cycle between.
//  Only req2 valid with 3 words then drops -> 3 writes, IDLE, burst_cnt reset, owner_id=2.
//  wfull high 5 cycles mid-burst of req1 -> winc=0 for 5 cycles, owner held, remaining words resume, none lost.
//  req1 and req3 valid, last=1 -> req3 granted first, then req1; data order per requester preserved in FIFO.
//  STATS_EN, CNT_WIDTH=4, 20 words from req0 -> wr_count lane0 saturates at 15, other lanes 0.

Source files
------------

// File: rtl/afifo_pkg.sv
// afifo_pkg: shared state type and index-width helper for the afifo write arbiter
package afifo_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/afifo_rr_pick.sv
// afifo_rr_pick: combinational round-robin pick of the first set request after last, wrapping
module afifo_rr_pick import afifo_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [idx_w(N)-1:0]  last,
    output logic [idx_w(N)-1:0]  idx,
    output logic                 found
);
    localparam int W = idx_w(N);
    logic [W-1:0] j;
    // Walk from the farthest offset down so the nearest requester after last wins
    always_comb begin
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((32'(last) + 32'(k)) % N);
            if (req[j]) begin
                idx = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter: round-robin burst arbiter driving the afifo write port in the wclk domain.
// Define AFIFO_WR_ARB_STATS_EN to add saturating per-requester wr_count statistics.
module afifo_wr_arbiter import afifo_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
`ifdef AFIFO_WR_ARB_STATS_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          wfull,
    output logic                          busy,
    output logic [idx_w(NUM_REQ)-1:0]     owner_id
`ifdef AFIFO_WR_ARB_STATS_EN
    , output logic [NUM_REQ*CNT_WIDTH-1:0] wr_count
`endif
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    arb_state_e state, state_d;
    logic [IW-1:0] owner_d, last, last_d, pick;
    logic [BW-1:0] burst_cnt, cnt_d;
    logic found, own_valid, last_word;
    logic [DATA_WIDTH-1:0] lane;

    afifo_rr_pick #(.N(NUM_REQ)) u_pick (
        .req(req_valid),
        .last(last),
        .idx(pick),
        .found(found)
    );

    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (owner_id == IW'(i)) lane = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign own_valid = req_valid[owner_id];
    assign busy      = state == ARB_BURST;
    assign winc      = busy && own_valid && !wfull;
    assign wdata     = winc ? lane : '0;
    assign req_ready = (busy && !wfull) ? NUM_REQ'(1) << owner_id : '0;
    assign last_word = burst_cnt == BW'(MAX_BURST - 1);

    // A full FIFO freezes the burst; a dropped valid only ends it once wfull clears
    always_comb begin
        state_d = state;
        owner_d = owner_id;
        last_d = last;
        cnt_d = burst_cnt;
        if (state == ARB_IDLE) begin
            if (found) begin
                state_d = ARB_BURST;
                owner_d = pick;
                last_d = pick;
                cnt_d = '0;
            end
        end else if (winc) begin
            cnt_d = last_word ? '0 : burst_cnt + 1'b1;
            state_d = last_word ? ARB_IDLE : ARB_BURST;
        end else if (!wfull && !own_valid) begin
            state_d = ARB_IDLE;
            cnt_d = '0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= ARB_IDLE;
            owner_id <= '0;
            last <= IW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state <= state_d;
            owner_id <= owner_d;
            last <= last_d;
            burst_cnt <= cnt_d;
        end
    end

`ifdef AFIFO_WR_ARB_STATS_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            wr_count <= '0;
        else
            for (int i = 0; i < NUM_REQ; i++)
                if (winc && owner_id == IW'(i) && !(&wr_count[i*CNT_WIDTH +: CNT_WIDTH]))
                    wr_count[i*CNT_WIDTH +: CNT_WIDTH] <= wr_count[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
    end
`endif
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// tb_afifo_wr_arbiter: scoreboard bench for afifo_wr_arbiter (grant order, burst length, data order, stalls, reset).
// Define AFIFO_WR_ARB_STATS_EN to also exercise wr_count saturation with CNT_WIDTH=4.
module tb_afifo_wr_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 8;
    logic clk = 1'b0;
    logic wrst_n = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*DW-1:0] req_data = '0;
    logic winc, busy;
    logic wfull = 1'b0;
    logic [DW-1:0] wdata;
    logic [1:0] owner_id;
`ifdef AFIFO_WR_ARB_STATS_EN
    logic [NR*4-1:0] wr_count;
`endif
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] src_q [NR][$];
    logic [DW-1:0] exp_q [NR][$];
    int exp_grant [$];
    int exp_len [$];
    logic full_now = 1'b0;
    logic busy_p = 1'b0;
    logic gap_chk = 1'b0;
    logic had_burst = 1'b0;
    int in_cnt = 0;
    int idle_run = 0;
    int seq = 0;

    afifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(NR),
        .MAX_BURST(MB)
`ifdef AFIFO_WR_ARB_STATS_EN
        , .CNT_WIDTH(4)
`endif
    ) dut (
        .wclk(clk),
        .wrst_n(wrst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .winc(winc),
        .wdata(wdata),
        .wfull(wfull),
        .busy(busy),
        .owner_id(owner_id)
`ifdef AFIFO_WR_ARB_STATS_EN
        , .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input int n);
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = {8'(r), 8'h5a, 16'(seq)};
            seq++;
            src_q[r].push_back(d);
            exp_q[r].push_back(d);
        end
    endtask

    function automatic logic all_empty();
        return src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 && src_q[3].size() == 0;
    endfunction

    // Drive sources on the falling edge, sample outputs 1ns later, retire accepted words
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = src_q[i].size() > 0;
            req_data[i*DW +: DW] = src_q[i].size() > 0 ? src_q[i][0] : '0;
        end
        wfull = full_now;
        #1;
        if (busy && !busy_p) begin
            if (gap_chk && had_burst) check("idle_gap", 64'(idle_run), 1);
            if (exp_grant.size() > 0) check("grant", 64'(owner_id), 64'(exp_grant.pop_front()));
            else check("grant_extra", 64'(exp_grant.size()), 1);
            in_cnt = 0;
        end
        if (!busy && busy_p) begin
            if (exp_len.size() > 0) check("burst_len", 64'(in_cnt), 64'(exp_len.pop_front()));
            else check("len_extra", 64'(exp_len.size()), 1);
            had_burst = 1'b1;
        end
        idle_run = busy ? 0 : idle_run + 1;
        if (winc) begin
            in_cnt++;
            if (exp_q[owner_id].size() > 0) check("wdata", 64'(wdata), 64'(exp_q[owner_id].pop_front()));
            else check("wdata_extra", 64'(exp_q[owner_id].size()), 1);
        end else begin
            check("wdata_idle", 64'(wdata), 0);
        end
        if (busy) check("ready", 64'(req_ready), wfull ? 64'h0 : 64'h1 << owner_id);
        else check("ready_idle", 64'(req_ready), 0);
        for (int i = 0; i < NR; i++)
            if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
        busy_p = busy;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 400 && !(all_empty() && !busy_p)) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(n < 400), 1);
    endtask

    initial begin
        repeat (3) cycle();
        check("rst_busy", 64'(busy), 0);
        check("rst_winc", 64'(winc), 0);
        check("rst_owner", 64'(owner_id), 0);
        check("rst_ready", 64'(req_ready), 0);
        check("rst_wdata", 64'(wdata), 0);
        wrst_n = 1'b1;

        // All requesters valid: 0,1,2,3,0 with 8 words each and one idle cycle between
        push(0, 16);
        push(1, 8);
        push(2, 8);
        push(3, 8);
        exp_grant = '{0, 1, 2, 3, 0};
        exp_len = '{8, 8, 8, 8, 8};
        had_burst = 1'b0;
        gap_chk = 1'b1;
        drain();
        gap_chk = 1'b0;

        // Lone requester 2 drops after 3 words
        push(2, 3);
        exp_grant.push_back(2);
        exp_len.push_back(3);
        drain();
        check("drop_owner", 64'(owner_id), 2);
        check("drop_busy", 64'(busy), 0);

        // Full stall of 5 cycles in the middle of requester 1's burst
        push(1, 6);
        exp_grant.push_back(1);
        exp_len.push_back(6);
        in_cnt = 0;
        for (int n = 0; n < 50 && in_cnt < 2; n++) cycle();
        check("full_setup", 64'(in_cnt), 2);
        full_now = 1'b1;
        repeat (5) begin
            cycle();
            check("full_winc", 64'(winc), 0);
            check("full_owner", 64'(owner_id), 1);
            check("full_busy", 64'(busy), 1);
        end
        full_now = 1'b0;
        drain();

        // last=1 with requesters 1 and 3 pending: 3 wins first
        push(1, 3);
        push(3, 3);
        exp_grant = '{3, 1};
        exp_len = '{3, 3};
        drain();

        // Reset after 3 words of a burst, then requester 0 goes first
        push(2, 8);
        exp_grant.push_back(2);
        exp_len.push_back(8);
        in_cnt = 0;
        for (int n = 0; n < 50 && in_cnt < 3; n++) cycle();
        check("rst_setup", 64'(in_cnt), 3);
        @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 1);
        wrst_n = 1'b0;
        #1;
        check("mid_rst_winc", 64'(winc), 0);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_owner", 64'(owner_id), 0);
        check("mid_rst_ready", 64'(req_ready), 0);
        busy_p = 1'b0;
        in_cnt = 0;
        exp_len.delete(0);
        push(0, 2);
        exp_grant = '{0, 2};
        exp_len = '{2, 5};
        repeat (2) cycle();
        wrst_n = 1'b1;
        drain();

`ifdef AFIFO_WR_ARB_STATS_EN
        wrst_n = 1'b0;
        #1;
        check("stats_rst", 64'(wr_count), 0);
        cycle();
        wrst_n = 1'b1;
        push(0, 20);
        exp_grant = '{0, 0, 0};
        exp_len = '{8, 8, 4};
        drain();
        check("stats_lane0", 64'(wr_count[3:0]), 15);
        check("stats_others", 64'(wr_count[15:4]), 0);
`endif

        check("left_grants", 64'(exp_grant.size()), 0);
        check("left_lens", 64'(exp_len.size()), 0);
        for (int i = 0; i < NR; i++) check("left_words", 64'(exp_q[i].size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
